// File: rtl/vend_ctrl.sv
// Vending-machine transaction controller: coin credit accumulation, product
// selection against a price table, timed dispense gate, and change return.
module vend_ctrl #(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned PRICE0      = 5,
  parameter int unsigned PRICE1      = 10,
  parameter int unsigned PRICE2      = 15,
  parameter int unsigned PRICE3      = 20,
  parameter int unsigned MAX_CREDIT  = 40,
  parameter int unsigned DISP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                sel_valid,
  input  logic [1:0]          sel,
  input  logic                cancel,
  output logic [1:0]          S,
  output logic                G,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                busy
);

  localparam int unsigned CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam int unsigned SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   disp_cnt;
  logic [CREDIT_W-1:0] coin_amt;
  logic [CREDIT_W-1:0] price;
  logic [SUM_W-1:0]   coin_sum;
  logic               coin_ok;

  // Decode coin code and selected product price into 5-cent units
  always_comb begin
    coin_amt = '0;
    price    = '0;
    case (coin_val)
      2'd0:    coin_amt = CREDIT_W'(1);
      2'd1:    coin_amt = CREDIT_W'(2);
      2'd2:    coin_amt = CREDIT_W'(5);
      default: coin_amt = CREDIT_W'(10);
    endcase
    case (sel)
      2'd0:    price = CREDIT_W'(PRICE0);
      2'd1:    price = CREDIT_W'(PRICE1);
      2'd2:    price = CREDIT_W'(PRICE2);
      default: price = CREDIT_W'(PRICE3);
    endcase
    coin_sum = SUM_W'(credit) + SUM_W'(coin_amt);
    coin_ok  = (coin_sum <= SUM_W'(MAX_CREDIT));
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      disp_cnt     <= '0;
      S            <= 2'd0;
      G            <= 1'b0;
      credit       <= '0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
    end else begin
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      case (state)
        IDLE, CREDIT: begin
          if (cancel && (credit != '0)) begin
            state        <= CHANGE;
            busy         <= 1'b1;
            change_valid <= 1'b1;
            change_amt   <= credit;
            coin_reject  <= coin_valid;
          end else if (sel_valid && (credit >= price)) begin
            state       <= DISPENSE;
            busy        <= 1'b1;
            S           <= sel;
            G           <= 1'b1;
            credit      <= credit - price;
            disp_cnt    <= CNT_W'(DISP_CYCLES - 1);
            coin_reject <= coin_valid;
          end else begin
            // A refused selection still lets a coordinated coin through
            insufficient <= sel_valid;
            if (coin_valid) begin
              if (coin_ok) begin
                credit <= coin_sum[CREDIT_W-1:0];
                state  <= CREDIT;
              end else begin
                coin_reject <= 1'b1;
              end
            end
          end
        end
        DISPENSE: begin
          coin_reject <= coin_valid;
          if (disp_cnt == '0) begin
            G <= 1'b0;
            if (credit != '0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              change_amt   <= credit;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            disp_cnt <= disp_cnt - CNT_W'(1);
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          credit      <= '0;
          state       <= IDLE;
          busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios then random strobes, each cycle
// compared against a transaction-level model of credit, dispense and change.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic [1:0] S;
  logic       G;
  logic [7:0] credit;
  logic       coin_reject;
  logic       insufficient;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Reference model state (amounts in 5-cent units)
  int m_credit   = 0;
  int m_disp     = 0;   // gate cycles still to show, 0 when not dispensing
  bit m_chg      = 0;   // change being presented this cycle
  int m_s        = 0;
  int e_cr = 0, e_ins = 0, e_cv = 0, e_camt = 0;
  int price_tab[4] = '{5, 10, 15, 20};
  int coin_tab[4]  = '{1, 2, 5, 10};

  vend_ctrl dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .S(S), .G(G),
    .credit(credit), .coin_reject(coin_reject), .insufficient(insufficient),
    .change_valid(change_valid), .change_amt(change_amt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    e_cr = 0; e_ins = 0; e_cv = 0; e_camt = 0;
    if (rst) begin
      m_credit = 0; m_disp = 0; m_chg = 0; m_s = 0;
    end else if (m_chg) begin
      m_credit = 0; m_chg = 0; e_cr = int'(coin_valid);
    end else if (m_disp > 0) begin
      e_cr = int'(coin_valid);
      m_disp = m_disp - 1;
      if (m_disp == 0 && m_credit > 0) begin
        m_chg = 1; e_cv = 1; e_camt = m_credit;
      end
    end else if (cancel && m_credit > 0) begin
      m_chg = 1; e_cv = 1; e_camt = m_credit; e_cr = int'(coin_valid);
    end else if (sel_valid && m_credit >= price_tab[sel]) begin
      m_s = int'(sel);
      m_credit = m_credit - price_tab[sel];
      m_disp = 4;
      e_cr = int'(coin_valid);
    end else begin
      e_ins = int'(sel_valid);
      if (coin_valid) begin
        if (m_credit + coin_tab[coin_val] <= 40) m_credit = m_credit + coin_tab[coin_val];
        else e_cr = 1;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare every output
  task automatic cyc(input bit r, input bit cv, input int cc, input bit sv,
                     input int si, input bit cn);
    rst = r; coin_valid = cv; coin_val = 2'(cc);
    sel_valid = sv; sel = 2'(si); cancel = cn;
    @(posedge clk);
    model_step();
    #1;
    check("S", int'(S), m_s);
    check("G", int'(G), int'(m_disp > 0));
    check("credit", int'(credit), m_credit);
    check("coin_reject", int'(coin_reject), e_cr);
    check("insufficient", int'(insufficient), e_ins);
    check("change_valid", int'(change_valid), e_cv);
    check("change_amt", int'(change_amt), e_camt);
    check("busy", int'(busy), int'((m_disp > 0) || m_chg));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset for two cycles
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle_n(1);

    // Exact-price purchase of product 1
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    idle_n(6);

    // Purchase with change due
    cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle_n(7);

    // Insufficient credit, then cancel refunds
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle_n(2);

    // Credit ceiling, then cancel beats selection
    for (int i = 0; i < 4; i++) cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 1);
    idle_n(6);

    // Coin during dispense, then reset on the second gate cycle
    cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle_n(3);

    // Insufficient selection with a coin in the same cycle
    cyc(0, 1, 2, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle_n(2);

    // Randomized strobes
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 79) == 0),
          ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
          ($urandom_range(0, 11) == 0));
    end
    idle_n(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
